mem_port_arbiter: RTL

//  Shares one single-port memory between the pipeline's fetch (IF) and data (MEM) stages.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_lat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter: FSM state and grant-side encodings.
// Pure declarations, no timing or flow control of its own.
package mem_port_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_BUSY  = 2'd1,
    ST_MEM_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Access-latency down-counter: load sets the count, dec steps toward zero, zero flags expiry.
// Updates one cycle after load/dec; saturates at zero, no backpressure.
import mem_port_arbiter_pkg::*;

module mem_lat_counter (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between fetch and data stages; ready pulses MEM_LAT+1
// cycles after a grant. Losing/late requesters are stalled and simply wait, never dropped.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              port_en,
  output logic              port_we,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  input  logic [DATA_W-1:0] port_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be within 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  state_t state;
  grant_t last_grant;
  logic   mem_pend;
  logic   grant_mem;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  always_comb begin
    mem_pend  = mem_rd_req | mem_wr_req;
    // MEM wins a tie only when IF had the previous grant.
    grant_mem = mem_pend && (!if_req || (last_grant == GRANT_IF));
    cnt_load  = (state == ST_IDLE) && (mem_pend || if_req);
    cnt_dec   = ((state == ST_IF_BUSY) || (state == ST_MEM_BUSY)) && !cnt_zero;
  end

  mem_lat_counter u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_IF;
      port_en    <= 1'b0;
      port_we    <= 1'b0;
      port_addr  <= '0;
      port_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_mem) begin
            state      <= ST_MEM_BUSY;
            last_grant <= GRANT_MEM;
            port_en    <= 1'b1;
            port_we    <= mem_wr_req;
            port_addr  <= mem_addr;
            port_wdata <= mem_wdata;
          end else if (if_req) begin
            state      <= ST_IF_BUSY;
            last_grant <= GRANT_IF;
            port_en    <= 1'b1;
            port_we    <= 1'b0;
            port_addr  <= if_addr;
          end
        end
        ST_IF_BUSY: begin
          if (cnt_zero) begin
            if_rdata <= port_rdata;
            if_ready <= 1'b1;
            port_en  <= 1'b0;
            port_we  <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_MEM_BUSY: begin
          if (cnt_zero) begin
            if (!port_we) begin
              mem_rdata <= port_rdata;
            end
            mem_ready <= 1'b1;
            port_en   <= 1'b0;
            port_we   <= 1'b0;
            state     <= ST_DONE;
          end
        end
        default: begin
          // Requests still high here see their ready pulse and must drop before IDLE re-arbitrates.
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = (mem_rd_req | mem_wr_req) & ~mem_ready;

endmodule
